// File: rtl/serial_chain_pkg.sv
// Shared types and frame constants for the serial shift-chain engine.
// LOAD and LATCH widths are counted in serial ticks.
package serial_chain_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SHIFT,
        ST_LATCH
    } chain_state_e;

    localparam int LOAD_TICKS  = 2;
    localparam int LATCH_TICKS = 2;
    localparam int STEP_W      = 2;

endpackage

// File: rtl/serial_tick_gen.sv
// Free-running CLK_DIV divider producing a one-cycle tick.
// A synchronous clear restarts the count so frames begin phase-aligned.
module serial_tick_gen #(
    parameter int CLK_DIV = 5
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_clr,
    output logic o_tick
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q + CW'(1);
        if (i_clr || (cnt_q == LAST)) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign o_tick = (cnt_q == LAST) && !i_clr;

endmodule

// File: rtl/serial_chain_io.sv
// Drives a 595-style output chain and reads a 165-style input chain
// on one shared serial clock, one frame of max(OUT_W, IN_W) bits.
module serial_chain_io
    import serial_chain_pkg::*;
#(
    parameter int OUT_W        = 16,
    parameter int IN_W         = 16,
    parameter int CLK_DIV      = 5,
    parameter int MSB_FIRST    = 1,
    parameter int AUTO_REFRESH = 1
) (
    input  logic             i_CLK,
    input  logic             i_SYS_RESET,
    input  logic [OUT_W-1:0] i_out_data,
    input  logic             i_start,
    output logic             o_busy,
    output logic             o_SCLK,
    output logic             o_SDATA,
    output logic             o_OLATCH,
    output logic             o_ILATCH,
    input  logic             i_SDATA,
    output logic [IN_W-1:0]  o_in_data,
    output logic             o_in_valid,
    output logic             o_in_changed
);

    localparam int N  = (OUT_W > IN_W) ? OUT_W : IN_W;
    localparam int BW = (N > 1) ? $clog2(N) : 1;
    localparam logic [BW-1:0] LAST_BIT = BW'(N - 1);
    localparam logic [STEP_W-1:0] LOAD_LAST = STEP_W'(LOAD_TICKS - 1);
    localparam logic [STEP_W-1:0] LATCH_LAST = STEP_W'(LATCH_TICKS - 1);

    chain_state_e state_q, state_d;
    logic [STEP_W-1:0] step_q, step_d;
    logic [BW-1:0] bit_q, bit_d;
    logic phase_q, phase_d;
    logic [N-1:0] osh_q, osh_d;
    logic [N-1:0] ish_q, ish_d;
    logic sclk_q, sclk_d;
    logic sdata_q, sdata_d;
    logic olatch_q, olatch_d;
    logic ilatch_q, ilatch_d;
    logic busy_q, busy_d;
    logic [IN_W-1:0] in_data_q, in_data_d;
    logic in_valid_q, in_valid_d;
    logic in_changed_q, in_changed_d;

    logic tick;
    logic tick_clr;
    logic start;
    logic [N-1:0] out_frame;
    logic [IN_W-1:0] in_word;

    assign tick_clr = (state_q == ST_IDLE);
    assign start = tick_clr && ((AUTO_REFRESH != 0) || i_start);

    serial_tick_gen #(
        .CLK_DIV(CLK_DIV)
    ) u_tick (
        .i_clk  (i_CLK),
        .i_rst_n(i_SYS_RESET),
        .i_clr  (tick_clr),
        .o_tick (tick)
    );

    // Wire order lives in the top bit; short words are zero-padded in front.
    always_comb begin
        out_frame = '0;
        for (int i = 0; i < OUT_W; i++) begin
            if (MSB_FIRST != 0) begin
                out_frame[i] = i_out_data[i];
            end else begin
                out_frame[OUT_W-1-i] = i_out_data[i];
            end
        end
    end

    // Samples enter at bit 0, so the last IN_W samples sit in the low bits.
    always_comb begin
        in_word = '0;
        for (int i = 0; i < IN_W; i++) begin
            if (MSB_FIRST != 0) begin
                in_word[i] = ish_q[i];
            end else begin
                in_word[IN_W-1-i] = ish_q[i];
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        step_d       = step_q;
        bit_d        = bit_q;
        phase_d      = phase_q;
        osh_d        = osh_q;
        ish_d        = ish_q;
        sclk_d       = sclk_q;
        sdata_d      = sdata_q;
        olatch_d     = olatch_q;
        ilatch_d     = ilatch_q;
        busy_d       = busy_q;
        in_data_d    = in_data_q;
        in_valid_d   = 1'b0;
        in_changed_d = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d  = ST_LOAD;
                    osh_d    = out_frame << 1;
                    sdata_d  = out_frame[N-1];
                    ilatch_d = 1'b0;
                    busy_d   = 1'b1;
                    step_d   = '0;
                end
            end

            ST_LOAD: begin
                if (tick) begin
                    if (step_q == LOAD_LAST) begin
                        state_d  = ST_SHIFT;
                        ilatch_d = 1'b1;
                        phase_d  = 1'b0;
                        bit_d    = '0;
                    end else begin
                        step_d = step_q + STEP_W'(1);
                    end
                end
            end

            ST_SHIFT: begin
                if (tick) begin
                    if (!phase_q) begin
                        ish_d    = ish_q << 1;
                        ish_d[0] = i_SDATA;
                        sclk_d   = 1'b1;
                        phase_d  = 1'b1;
                    end else begin
                        sclk_d  = 1'b0;
                        phase_d = 1'b0;
                        if (bit_q == LAST_BIT) begin
                            state_d  = ST_LATCH;
                            olatch_d = 1'b1;
                            step_d   = '0;
                        end else begin
                            bit_d   = bit_q + BW'(1);
                            sdata_d = osh_q[N-1];
                            osh_d   = osh_q << 1;
                        end
                    end
                end
            end

            ST_LATCH: begin
                if (tick) begin
                    if (step_q == LATCH_LAST) begin
                        state_d      = ST_IDLE;
                        olatch_d     = 1'b0;
                        busy_d       = 1'b0;
                        in_data_d    = in_word;
                        in_valid_d   = 1'b1;
                        in_changed_d = (in_word != in_data_q);
                    end else begin
                        step_d = step_q + STEP_W'(1);
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_CLK or negedge i_SYS_RESET) begin
        if (!i_SYS_RESET) begin
            state_q      <= ST_IDLE;
            step_q       <= '0;
            bit_q        <= '0;
            phase_q      <= 1'b0;
            osh_q        <= '0;
            ish_q        <= '0;
            sclk_q       <= 1'b0;
            sdata_q      <= 1'b0;
            olatch_q     <= 1'b0;
            ilatch_q     <= 1'b1;
            busy_q       <= 1'b0;
            in_data_q    <= '0;
            in_valid_q   <= 1'b0;
            in_changed_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            step_q       <= step_d;
            bit_q        <= bit_d;
            phase_q      <= phase_d;
            osh_q        <= osh_d;
            ish_q        <= ish_d;
            sclk_q       <= sclk_d;
            sdata_q      <= sdata_d;
            olatch_q     <= olatch_d;
            ilatch_q     <= ilatch_d;
            busy_q       <= busy_d;
            in_data_q    <= in_data_d;
            in_valid_q   <= in_valid_d;
            in_changed_q <= in_changed_d;
        end
    end

    assign o_busy       = busy_q;
    assign o_SCLK       = sclk_q;
    assign o_SDATA      = sdata_q;
    assign o_OLATCH     = olatch_q;
    assign o_ILATCH     = ilatch_q;
    assign o_in_data    = in_data_q;
    assign o_in_valid   = in_valid_q;
    assign o_in_changed = in_changed_q;

endmodule

// File: doc/serial_chain_io.md
# serial_chain_io

Parametrised serial shift-chain engine. One frame shifts a parallel word out to a 74HC595-style output chain (LEDs, seven-segment) and, on the same serial clock, shifts a 74HC165-style input chain (DIP switches) in. It generalises the fixed-width LED, seven-segment and DIP drivers into one block. It adds:

- configurable widths, bit order and clock divide;
- one-shot or auto-refresh operation;
- a frame-valid strobe and change-detect on the input word.

It sits between the top level's board pins and the user logic.

## Interface
Parameters:
- OUT_W, 16, output chain length in bits (≥1)
- IN_W, 16, input chain length in bits (≥1)
- CLK_DIV, 5, i_CLK cycles per serial tick (≥2)
- MSB_FIRST, 1, 1: word MSB is first on the wire; 0: LSB first
- AUTO_REFRESH, 1, 1: frames run back-to-back; 0: a frame runs only on i_start

Ports (one clock; reset is asynchronous and active-low):
- i_CLK, in, 1, system clock
- i_SYS_RESET, in, 1, asynchronous active-low reset
- i_out_data, in, OUT_W, word to drive onto the output chain
- i_start, in, 1, frame request; used only when AUTO_REFRESH=0
- o_busy, out, 1, frame in progress
- o_SCLK, out, 1, shared serial clock
- o_SDATA, out, 1, serial data to the output chain
- o_OLATCH, out, 1, output-chain storage latch; active-high pulse
- o_ILATCH, out, 1, input-chain parallel load; active-low
- i_SDATA, in, 1, serial data from the input chain
- o_in_data, out, IN_W, last completed input word
- o_in_valid, out, 1, one-cycle pulse when o_in_data updates
- o_in_changed, out, 1, one-cycle pulse, coincident with o_in_valid, when the new word differs from the previous one

## Operation
- N = max(OUT_W, IN_W) bits per frame.
- tick: one-cycle pulse every CLK_DIV cycles. The tick counter is cleared on frame start.
- States: IDLE, LOAD, SHIFT, LATCH.
- IDLE
  - Outputs: o_SCLK=0, o_ILATCH=1, o_OLATCH=0, o_busy=0.
  - A frame starts when (AUTO_REFRESH=1) or i_start=1.
  - On start: snapshot i_out_data into the output shift register, set o_busy=1, go to LOAD.
- LOAD
  - o_ILATCH=0 for 2 ticks, then o_ILATCH=1, then go to SHIFT.
  - o_SDATA already carries bit 0 of the frame.
- SHIFT: each bit occupies 2 ticks.
  - Phase 0: o_SCLK=0.
  - Tick ending phase 0: sample i_SDATA, then raise o_SCLK.
  - Tick ending phase 1: drop o_SCLK and advance o_SDATA.
  - After bit N-1, go to LATCH.
- LATCH
  - o_OLATCH=1 for 2 ticks.
  - At its end: update o_in_data, pulse o_in_valid (and o_in_changed if applicable), clear o_busy, return to IDLE.
- Output padding: when OUT_W<N, the first N−OUT_W bits driven are 0, so real data lands at the chain end.
- Input trimming: when IN_W<N, only the last IN_W samples are kept.
- Bit order:
  - MSB_FIRST=1: wire order is i_out_data[OUT_W-1] down to [0]; the first kept input sample goes to o_in_data[IN_W-1].
  - MSB_FIRST=0: mirrored.
- i_start during a frame is ignored; no queueing.
- Changes to i_out_data mid-frame have no effect until the next snapshot.
- o_in_changed compares against the previous o_in_data. After reset the comparison value is 0.
- Reset, including mid-frame: immediate return to IDLE. Outputs take their IDLE values, o_in_data=0, o_in_valid=0, o_in_changed=0. Partial frame data is discarded.

## Timing
- Start acceptance edge = cycle 0. The first tick occurs at cycle CLK_DIV.
- Frame = 2N+4 ticks.
- o_in_valid is high for exactly one cycle, at cycle (2N+4)·CLK_DIV. o_busy falls on the same edge.
- Example: N=16, CLK_DIV=5 gives 180 cycles.
- AUTO_REFRESH=1: exactly one IDLE cycle between frames, so the period is (2N+4)·CLK_DIV+1 cycles.
- All outputs are registered and glitch-free. o_SCLK high and low phases are each CLK_DIV cycles.
- o_SDATA changes only on the falling edge of o_SCLK (or on LOAD entry), giving CLK_DIV cycles of setup before a rising edge.

## Structure
- Shared package/include serial_chain_pkg holds:
  - state encodings (IDLE/LOAD/SHIFT/LATCH);
  - the LOAD and LATCH widths (2 ticks each).
- Sub-module serial_tick_gen: a CLK_DIV counter with a synchronous clear, producing tick.
- Top body contains the FSM, bit counter, phase flag, output shift register and input shift register.

## Test plan
- Defaults, AUTO_REFRESH=0. Drive i_out_data=16'hA5C3 and pulse i_start.
  - Required: wire sequence on o_SDATA is 1010_0101_1100_0011.
  - Exactly 16 rising edges of o_SCLK.
  - o_OLATCH pulse of 10 cycles.
  - o_in_valid at cycle 180.
- Input model loads 16'h1234 on o_ILATCH low and shifts on o_SCLK rise.
  - Required: o_in_data=16'h1234 and o_in_changed=1.
  - Required on a repeat frame: o_in_changed=0.
- OUT_W=8, IN_W=12, MSB_FIRST=0, i_out_data=8'h81.
  - Required: 4 leading zeros, then 1000_0001.
  - Required: the last 12 input samples are mapped LSB-first.
- AUTO_REFRESH=1, CLK_DIV=2.
  - Required: successive o_in_valid pulses exactly 73 cycles apart.
  - Required: i_out_data changed mid-frame appears only in the next frame.
- Assert i_SYS_RESET low in the middle of SHIFT.
  - Required: all outputs return to reset values asynchronously.
  - Required: no o_in_valid pulse for the aborted frame.
  - Required: a clean frame follows release.
- Pulse i_start again while o_busy=1.
  - Required: ignored, with exactly one frame completing.
